seg7_byte_scan: RTL
===================

# seg7_byte_scan

Downstream display stage for the 32-bit free-running counter. It takes the counter's switch-selected 8-bit LED byte and the 2-bit byte-select value, and drives a 4-digit, common-anode, multiplexed seven-segment display. Digits 1:0 show the byte in hex, digit 3 shows the select index, and digit 2 is blank. Inputs are snapshotted once per scan frame, so a digit pair never shows a torn value while the counter is running.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 4.
- `BLANK_CYCLES`, default 500: anode-off cycles at the start of each slot; must be < `REFRESH_DIV`. Used only when `SEG7_GHOST_BLANK_EN` is defined.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `data`  input  8  byte to display (from the counter's LED output).
- `sel`  input  2  byte index currently selected ({sw1, sw0}).
- `an`  output  4  digit anodes, active-low; `an[0]` is the rightmost digit.
- `seg`  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- `dp`  output  1  decimal point, active-low.
- `frame_tick`  output  1  one-cycle pulse on the cycle the shadow registers load.

## Operation
- Prescaler `pcnt` counts 0 .. `REFRESH_DIV`-1, then wraps to 0. Its terminal count (`pcnt == REFRESH_DIV-1`) advances digit index `idx`.
- `idx` is a 2-bit state: D0 → D1 → D2 → D3 → D0.
- Frame start occurs in two cases, and on it the shadow registers `data_s` and `sel_s` load from `data`/`sel` and `frame_tick` = 1:
  - the first clock edge after `rst` deasserts;
  - every D3 → D0 transition.
- Digit content per state:
  - D0: `an`=1110, `seg` = hex(`data_s[3:0]`).
  - D1: `an`=1101, `seg` = hex(`data_s[7:4]`).
  - D2: `an`=1011, `seg`=1111111 (blank).
  - D3: `an`=0111, `seg` = hex({2'b00, `sel_s`}).
- `dp` = 0 only in D1, separating the hex pair from the index; otherwise 1.
- Hex encoding examples: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 5=0010010, A=0001000.
- `data`/`sel` changes mid-frame have no visible effect until the next frame start.

## Timing
- Reset values: `pcnt`=0, `idx`=D0, `data_s`=0, `sel_s`=0, `an`=1111, `seg`=1111111, `dp`=1, `frame_tick`=0.
- `an`/`seg`/`dp` are registered and reflect `idx`/`data_s` with 1-cycle latency, so:
  - the first edge after reset release drives D0 of the previous (reset) shadow, i.e. '0';
  - the new shadow appears on the following edge.
- Each slot lasts exactly `REFRESH_DIV` cycles; one frame is 4·`REFRESH_DIV` cycles.
- `frame_tick` pulses in the same cycle `idx` becomes D0. It is never asserted in two consecutive cycles.
- Reset asserted mid-slot: all outputs go to reset values immediately (asynchronous); the scan restarts at D0.

## Configuration
- `SEG7_GHOST_BLANK_EN` defined:
  - while `pcnt` < `BLANK_CYCLES`, `an`=1111, `seg`=1111111 and `dp`=1;
  - normal drive resumes when `pcnt` = `BLANK_CYCLES` (observed one cycle later).
- Not defined: no blanking; anodes switch directly between digits and `BLANK_CYCLES` is ignored.

## Structure
- Shared package holds:
  - digit-state encodings D0..D3;
  - active-low anode patterns;
  - `SEG_BLANK` = 7'b1111111;
  - the 16-entry hex segment constants.
- One combinational sub-module, `hex_to_seg7` (4-bit in, 7-bit active-low out), instantiated once on the muxed nibble.
- The prescaler, `idx` FSM, shadow registers and output registers stay in the top module.

## Test plan
All scenarios use `REFRESH_DIV`=4, `BLANK_CYCLES`=1.
- Reset held low → `an`=1111, `seg`=1111111, `dp`=1, `frame_tick`=0.
- Release reset with `data`=8'h35, `sel`=2 → `frame_tick` on the first edge; the digit cycle after the 3 settles is:
  - D0: `an`=1110, `seg`=0010010 ('5');
  - D1: `an`=1101, `seg`=0110000 ('3'), `dp`=0;
  - D2: `an`=1011, blank;
  - D3: `an`=0111, `seg`=0100100 ('2').
- Change `data` to 8'hA1 in the middle of D1 → D1 still shows '3'. After the next `frame_tick`, D0 shows 1111001 ('1') and D1 shows 0001000 ('A').
- Count cycles between successive `frame_tick` pulses → exactly 16; each `an` pattern is held for 4 cycles.
- Assert `rst` low during D2 → outputs reach reset values with no clock edge. After release the scan starts at D0.
- With `SEG7_GHOST_BLANK_EN` defined → first cycle of each slot has `an`=1111, and the remaining 3 cycles have the correct anode pattern.

Source files
------------

// File: rtl/seg7_byte_scan_pkg.sv
// seg7_byte_scan_pkg
// Shared constants for the seven-segment byte scanner: digit-state encoding,
// active-low anode patterns, the blank segment pattern and the hex font.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package seg7_byte_scan_pkg;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } digit_e;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index 15 first so that HEX_SEG[n] is the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_byte_scan_hex_to_seg7.sv
// hex_to_seg7
// Combinational hex-digit decoder for a common-anode seven-segment digit.
// Ports:
//   i_nibble  4-bit value to display
//   o_seg     segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import seg7_byte_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_byte_scan.sv
// seg7_byte_scan
// Four-digit multiplexed seven-segment driver. Digits 1:0 show a byte in hex,
// digit 3 shows the 2-bit select index, digit 2 is blank. Inputs are
// snapshotted once per scan frame so the hex pair never shows a torn value.
// Optional feature macro: SEG7_GHOST_BLANK_EN (anode-off gap at slot start).
// Parameters:
//   REFRESH_DIV   clock cycles per digit slot (>= 4)
//   BLANK_CYCLES  anode-off cycles at slot start (< REFRESH_DIV), ghost build only
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_data         byte to display
//   i_sel          byte index shown on digit 3
//   o_an           digit anodes, active-low, o_an[0] rightmost
//   o_seg          cathodes {g,f,e,d,c,b,a}, active-low
//   o_dp           decimal point, active-low (lit on digit 1 only)
//   o_frame_tick   one-cycle pulse when the shadow registers load
module seg7_byte_scan
    import seg7_byte_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic [1:0] i_sel,
    output logic [3:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic       o_frame_tick
);

    localparam int unsigned PCNT_W = $clog2(REFRESH_DIV);

    logic [PCNT_W-1:0] r_pcnt;
    digit_e            r_idx;
    logic              r_started;  // low until the first edge after reset
    logic [7:0]        r_data_s;
    logic [1:0]        r_sel_s;

    logic [PCNT_W-1:0] w_pcnt_d;
    digit_e            w_idx_d;
    logic              w_frame_start;
    logic              w_tc;
    logic [3:0]        w_nibble;
    logic [6:0]        w_hex;
    logic [3:0]        w_an;
    logic [6:0]        w_seg;
    logic              w_dp;

    assign w_tc = (r_pcnt == PCNT_W'(REFRESH_DIV - 1));

    hex_to_seg7 u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_hex)
    );

    // Next-state: prescaler, digit index and frame start.
    always_comb begin
        w_pcnt_d      = r_pcnt + 1'b1;
        w_idx_d       = r_idx;
        w_frame_start = !r_started;
        if (w_tc) begin
            w_pcnt_d = '0;
            unique case (r_idx)
                D0: w_idx_d = D1;
                D1: w_idx_d = D2;
                D2: w_idx_d = D3;
                D3: begin
                    w_idx_d       = D0;
                    w_frame_start = 1'b1;
                end
            endcase
        end
    end

    // Output decode from the current index and shadow; registered below.
    always_comb begin
        w_nibble = r_data_s[3:0];
        w_an     = AN_D0;
        w_seg    = w_hex;
        w_dp     = 1'b1;
        unique case (r_idx)
            D0: begin
                w_nibble = r_data_s[3:0];
                w_an     = AN_D0;
            end
            D1: begin
                w_nibble = r_data_s[7:4];
                w_an     = AN_D1;
                w_dp     = 1'b0;
            end
            D2: begin
                w_an  = AN_D2;
                w_seg = SEG_BLANK;
            end
            D3: begin
                w_nibble = {2'b00, r_sel_s};
                w_an     = AN_D3;
            end
        endcase
`ifdef SEG7_GHOST_BLANK_EN
        // Dark gap lets the previous digit's cathodes settle before the next anode.
        if (32'(r_pcnt) < BLANK_CYCLES) begin
            w_an  = AN_OFF;
            w_seg = SEG_BLANK;
            w_dp  = 1'b1;
        end
`endif
    end

`ifndef SEG7_GHOST_BLANK_EN
    logic w_unused_blank_cfg;
    assign w_unused_blank_cfg = (BLANK_CYCLES < REFRESH_DIV);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt       <= '0;
            r_idx        <= D0;
            r_started    <= 1'b0;
            r_data_s     <= '0;
            r_sel_s      <= '0;
            o_an         <= AN_OFF;
            o_seg        <= SEG_BLANK;
            o_dp         <= 1'b1;
            o_frame_tick <= 1'b0;
        end else begin
            r_pcnt       <= w_pcnt_d;
            r_idx        <= w_idx_d;
            r_started    <= 1'b1;
            o_an         <= w_an;
            o_seg        <= w_seg;
            o_dp         <= w_dp;
            o_frame_tick <= w_frame_start;
            if (w_frame_start) begin
                r_data_s <= i_data;
                r_sel_s  <= i_sel;
            end
        end
    end

endmodule
